// File: rtl/key_press_pulser.sv
// Player-key conditioner: 2-flop sync, debounce filter (only with KEY_DEBOUNCE_EN), press FSM -> one 1-cycle L/R strobe per press.
// Latency DEBOUNCE_CYCLES+2 edges (2 edges without KEY_DEBOUNCE_EN); no backpressure, strobes dropped while enable=0.
module key_press_pulser #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  input  logic enable,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    HELD     = 2'd2
  } state_t;

`ifdef KEY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`endif

  // A filter length below one cycle is meaningless; leaves an empty marker block if mis-set.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
  end

  logic [1:0] w_key_n;
  logic [1:0] w_pulse;
  logic [1:0] w_held;

  assign w_key_n = {key_r_n, key_l_n};

  // Channel 0 = left, channel 1 = right; the two never interact.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic   r_sync1;
    logic   r_sync2;
    logic   w_deb_n;
    state_t r_state;
    state_t w_state_nxt;
    logic   w_pulse_nxt;
    logic   r_pulse;
    logic   r_held;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= w_key_n[g];
        r_sync2 <= r_sync1;
      end
    end

`ifdef KEY_DEBOUNCE_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb_n;

    // Debounced level starts as "pressed" so a key held through reset cannot fire.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt   <= '0;
        r_deb_n <= 1'b0;
      end else if (r_sync2 == r_deb_n) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb_n <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end

    assign w_deb_n = r_deb_n;
`else
    assign w_deb_n = r_sync2;
`endif

    always_comb begin
      w_state_nxt = r_state;
      w_pulse_nxt = 1'b0;
      case (r_state)
        WAIT_REL: if (w_deb_n) w_state_nxt = IDLE;
        IDLE: begin
          if (!w_deb_n) begin
            w_state_nxt = HELD;
            w_pulse_nxt = enable;
          end
        end
        HELD:     if (w_deb_n) w_state_nxt = IDLE;
        default:  w_state_nxt = WAIT_REL;
      endcase
    end

    // held tracks the next state so it rises on the same edge as the strobe.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= WAIT_REL;
        r_pulse <= 1'b0;
        r_held  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_pulse <= w_pulse_nxt;
        r_held  <= (w_state_nxt == HELD);
      end
    end

    assign w_pulse[g] = r_pulse;
    assign w_held[g]  = r_held;
  end

  assign L      = w_pulse[0];
  assign R      = w_pulse[1];
  assign held_l = w_held[0];
  assign held_r = w_held[1];

endmodule

// File: tb/tb_key_press_pulser.sv
// Directed bench for key_press_pulser; expected timing follows the KEY_DEBOUNCE_EN setting of the build.
module tb_key_press_pulser;

  localparam int DC = 4;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT = DC + 2;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_l_n = 1'b1;
  logic key_r_n = 1'b1;
  logic enable = 1'b1;
  logic L, R, held_l, held_r;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic       kl;
    logic       kr;
    logic       en;
    logic [3:0] exp;   // {L, R, held_l, held_r}
  } vec_t;

  vec_t vecs[$];

  key_press_pulser #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .enable  (enable),
    .L       (L),
    .R       (R),
    .held_l  (held_l),
    .held_r  (held_r)
  );

  always #5 clk = ~clk;

  task automatic add(input string tag, input logic rst, input logic kl, input logic kr,
                     input logic en, input logic e_l, input logic e_r,
                     input logic e_hl, input logic e_hr);
    vec_t v;
    v.tag = tag;
    v.rst = rst;
    v.kl  = kl;
    v.kr  = kr;
    v.en  = en;
    v.exp = {e_l, e_r, e_hl, e_hr};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: {L,R,held_l,held_r} got %b expected %b", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read one full cycle later, after the next rising edge.
  task automatic step(input logic rst, input logic kl, input logic kr, input logic en);
    reset   = rst;
    key_l_n = kl;
    key_r_n = kr;
    enable  = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset and settle with keys released
    for (int i = 0; i < 2; i++) add("reset", 1, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add("idle_after_reset", 0, 1, 1, 1, 0, 0, 0, 0);
    // Long left press: one strobe at LAT, held from LAT
    for (int i = 0; i < 20; i++) add("left_press", 0, 0, 1, 1, i == LAT, 0, i >= LAT, 0);
    for (int i = 0; i < 10; i++) add("left_release", 0, 1, 1, 1, 0, 0, i < LAT, 0);
`ifdef KEY_DEBOUNCE_EN
    // Press exactly DC cycles long is the shortest accepted one
    for (int i = 0; i < 16; i++)
      add("left_min_press", 0, (i < DC) ? 1'b0 : 1'b1, 1, 1, i == LAT, 0,
          (i >= LAT) && (i < LAT + DC), 0);
    // Right glitch of DC-1 cycles is rejected
    for (int i = 0; i < 11; i++)
      add("right_glitch", 0, 1, (i < DC - 1) ? 1'b0 : 1'b1, 1, 0, 0, 0, 0);
    // Reset in the middle of a left debounce, key still held afterwards
    for (int i = 0; i < 3; i++) add("mid_debounce_press", 0, 0, 1, 1, 0, 0, 0, 0);
    add("mid_debounce_reset", 1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add("held_after_mid_reset", 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) add("release_after_mid_reset", 0, 1, 1, 1, 0, 0, 0, 0);
`endif
    // Right press
    for (int i = 0; i < 10; i++) add("right_press", 0, 1, 0, 1, 0, i == LAT, 0, i >= LAT);
    for (int i = 0; i < 10; i++) add("right_release", 0, 1, 1, 1, 0, 0, 0, i < LAT);
    // Both keys on the same edge
    for (int i = 0; i < 12; i++)
      add("both_press", 0, 0, 0, 1, i == LAT, i == LAT, i >= LAT, i >= LAT);
    for (int i = 0; i < 10; i++) add("both_release", 0, 1, 1, 1, 0, 0, i < LAT, i < LAT);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].kl, vecs[k].kr, vecs[k].en);
      check($sformatf("%s[%0d]", vecs[k].tag, k), {L, R, held_l, held_r}, vecs[k].exp);
    end

    // Press accepted while disabled is lost; raising enable mid-hold gives nothing
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      check("en0_press", {L, R, held_l, held_r}, {1'b0, 1'b0, i >= LAT, 1'b0});
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 1);
      check("enable_raised_while_held", {L, R, held_l, held_r}, 4'b0010);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 1);
      check("en_release", {L, R, held_l, held_r}, {1'b0, 1'b0, i < LAT, 1'b0});
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1);
      check("repress_enabled", {L, R, held_l, held_r}, {i == LAT, 1'b0, i >= LAT, 1'b0});
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 1);
      check("repress_release", {L, R, held_l, held_r}, {1'b0, 1'b0, i < LAT, 1'b0});
    end

`ifdef KEY_DEBOUNCE_EN
    // Left key held through reset: silent until released and pressed again
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 1, 1);
      check("held_through_reset", {L, R, held_l, held_r}, 4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 1);
      check("release_after_reset_hold", {L, R, held_l, held_r}, 4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1);
      check("press_after_reset_hold", {L, R, held_l, held_r}, {i == LAT, 1'b0, i >= LAT, 1'b0});
    end
`else
    // Without the filter a single-cycle glitch counts as a press
    for (int i = 0; i < 8; i++) begin
      step(0, (i == 0) ? 1'b0 : 1'b1, 1, 1);
      check("one_cycle_glitch", {L, R, held_l, held_r}, {i == 2, 1'b0, i == 2, 1'b0});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
